// File: rtl/ahb_lite_master.sv
// AHB-lite initiator: byte requests are buffered in a FIFO and issued as pipelined single NONSEQ transfers.
// Define AHB_LITE_MASTER_WR_ACK_EN to also pulse rsp_valid on write completions.
`timescale 1ns/1ps
module ahb_lite_master #(
   parameter int ADDR_W     = 21,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [1:0]        HTRANS,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   input  logic [DATA_W-1:0] HRDATA
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_NONSEQ = 2'b10
   } htrans_t;

   logic [ADDR_W-1:0]     f_addr  [FIFO_DEPTH];
   logic [DATA_W-1:0]     f_wdata [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] f_write;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW:0]           count;

   htrans_t               trans_q;
   logic [DATA_W-1:0]     ap_wdata;
   logic                  dp_v;
   logic                  dp_write;

   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  complete;

   assign full      = (count == (PW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign req_ready = !full && !HRESET;
   assign push      = req_valid && req_ready;
   assign pop       = HREADY && !empty;
   assign HTRANS    = trans_q;
   assign busy      = !empty || (trans_q == TR_NONSEQ) || dp_v;

`ifdef AHB_LITE_MASTER_WR_ACK_EN
   assign complete  = HREADY && dp_v;
`else
   assign complete  = HREADY && dp_v && !dp_write;
`endif

   // Storage needs no reset: only entries counted in 'count' are ever read.
   always_ff @(posedge HCLK) begin
      if (push) begin
         f_addr[wr_ptr]  <= req_addr;
         f_wdata[wr_ptr] <= req_wdata;
         f_write[wr_ptr] <= req_write;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Address and data phases advance together, only on HREADY edges.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         trans_q   <= TR_IDLE;
         HADDR     <= '0;
         HWRITE    <= 1'b0;
         HWDATA    <= '0;
         ap_wdata  <= '0;
         dp_v      <= 1'b0;
         dp_write  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= complete;
         if (complete && !dp_write) rsp_rdata <= HRDATA;
         if (HREADY) begin
            dp_v     <= (trans_q == TR_NONSEQ);
            dp_write <= HWRITE;
            HWDATA   <= ((trans_q == TR_NONSEQ) && HWRITE) ? ap_wdata : '0;
            if (!empty) begin
               trans_q  <= TR_NONSEQ;
               HADDR    <= f_addr[rd_ptr];
               HWRITE   <= f_write[rd_ptr];
               ap_wdata <= f_wdata[rd_ptr];
            end else begin
               trans_q  <= TR_IDLE;
            end
         end
      end
   end

endmodule
